// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_sequencer_pkg;

  localparam int ROM_WORDS_DEFAULT = 256;
  localparam int ROM_ADDR_W_DEFAULT = $clog2(ROM_WORDS_DEFAULT);

  typedef logic [31:0] word_t;
  typedef logic [ROM_ADDR_W_DEFAULT-1:0] rom_address_t;

  localparam word_t R_NOP = 32'h0000_0013;
  localparam word_t ERASED_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    word_t pc;
    word_t word;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_e;

  // ROM spans 2^(addr_w+2) bytes; any higher pc bit set means out of range
  function automatic logic pc_in_range(word_t pc, int addr_w);
    return (pc >> (addr_w + 2)) == '0;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {pc, word} prefetch FIFO; flush overrides push/pop,
// push+pop is legal while full.
module fetch_queue
  import fetch_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign head  = entry_q[rd_ptr_q];

  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        entry_d[wr_ptr_q] = push_entry;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller: PC, ROM addressing, prefetch queue, redirects.
// FETCH_ERASED_TRAP_EN: fault instead of pushing an erased (all-ones) ROM word.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          ROM_WORDS = 256,
  parameter int          ADDR_W    = $clog2(ROM_WORDS),
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_out,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_word,
  output logic              fault,
  output logic [31:0]       fault_pc
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        fault_pc_q, fault_pc_d;

  logic         q_push, q_pop, q_flush, q_full, q_empty;
  fetch_entry_t q_head;
  fetch_entry_t q_push_entry;
  logic         rom_erased;

  fetch_queue u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .flush      (q_flush),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign rom_address  = pc_q[ADDR_W+1:2];
  assign q_push_entry = '{pc: pc_q, word: rom_out};

  assign fetch_valid = !q_empty;
  assign fetch_pc    = fetch_valid ? q_head.pc : '0;
  assign fetch_word  = fetch_valid ? q_head.word : R_NOP;
  assign fault       = (state_q == FETCH_FAULT);
  assign fault_pc    = fault_pc_q;

`ifdef FETCH_ERASED_TRAP_EN
  assign rom_erased = (rom_out == ERASED_WORD);
`else
  assign rom_erased = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    q_pop      = fetch_valid && fetch_ready;
    if (redirect_valid) begin
      // the queue's flush wins over the pop, so no pop is credited this cycle
      q_flush = 1'b1;
      pc_d    = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = FETCH_FAULT;
        fault_pc_d = redirect_pc;
      end else begin
        state_d    = FETCH_RUN;
        fault_pc_d = '0;
      end
    end else if (state_q == FETCH_RUN) begin
      if (!pc_in_range(pc_q, ADDR_W)) begin
        state_d    = FETCH_FAULT;
        fault_pc_d = pc_q;
      end else if (!q_full || q_pop) begin
        if (rom_erased) begin
          state_d    = FETCH_FAULT;
          fault_pc_d = pc_q;
        end else begin
          q_push = 1'b1;
          pc_d   = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the ROM address port and hands fetched words to the decode stage.
- Keeps a byte-address PC and a 2-entry prefetch queue of {pc, word} pairs.
- Uses a valid/ready handshake toward decode and accepts redirects (branches/jumps) that flush the queue.
- Sits between rom (asynchronous read: rom_out follows rom_address in the same cycle) and the instruction_decoder input register.

Parameters:
- ROM_WORDS, 256: ROM depth in 32-bit words; must be a power of two.
- ADDR_W, $clog2(ROM_WORDS): width of RomAddress (word index).
- RESET_PC, 32'h0000_0000: byte address fetched first after reset; must be 4-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rom_address  out  ADDR_W  word index into ROM, equal to pc[ADDR_W+1:2].
- rom_out  in  32  ROM read data for the current rom_address.
- redirect_valid  in  1  load a new PC and flush the queue.
- redirect_pc  in  32  byte target of the redirect.
- fetch_valid  out  1  queue head holds a valid instruction.
- fetch_ready  in  1  decode accepts the head this cycle.
- fetch_pc  out  32  byte address of the head word.
- fetch_word  out  32  head instruction word; reads R_NOP (32'h0000_0013) when fetch_valid=0.
- fault  out  1  sequencer is in the FAULT state.
- fault_pc  out  32  PC that caused the fault.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc=RESET_PC; queue empty; state=RUN.
  - fetch_valid=0, fetch_word=R_NOP, fetch_pc=0, fault=0, fault_pc=0.
- States:
  - RUN: fetching.
  - FAULT: fetch halted; rom_address holds its last value; the queue keeps draining to decode.
- Push, evaluated in RUN every cycle:
  - If the queue is not full after this cycle's pop, or the queue has a free slot: push {pc, rom_out} and set pc+=4.
  - Push and pop may occur in the same cycle, including when the queue is full and fetch_ready=1. This sustains 1 instruction/cycle.
- Pop: occurs when fetch_valid && fetch_ready. The head advances on the edge.
- Latency:
  - A word pushed at edge N is visible at the head after edge N.
  - First fetch_valid=1 is in the cycle after the first rising edge with reset_n=1.
- Out-of-range: if pc >= ROM_WORDS*4 in RUN, go to FAULT with fault_pc=pc. Nothing is pushed.
- Redirect (redirect_valid=1), highest priority:
  - Queue flushed, with no pop credited that cycle.
  - pc=redirect_pc; state=RUN; fault cleared.
  - No push that cycle.
  - If redirect_pc[1:0]!=0: go to FAULT with fault_pc=redirect_pc instead of RUN.
  - fetch_valid=0 in the next cycle. The first target word is visible 2 cycles after the redirect edge.
- A redirect while in FAULT is the only way out of FAULT besides reset.
- Reset asserted mid-operation: immediate return to reset values, with no waiting for the clock.
- PC arithmetic: 32-bit, wraps modulo 2^32. The range check catches wrap.

Optional Feature:
- Macro: FETCH_ERASED_TRAP_EN.
- Defined:
  - A ROM word equal to 32'hFFFF_FFFF (erased cell) is not pushed.
  - The sequencer enters FAULT with fault_pc=pc.
  - Earlier queued words still drain.
- Undefined: 32'hFFFF_FFFF is pushed like any other word, and the decoder flags it as illegal.

Decomposition:
- Shared package:
  - Word, RomAddress, R_NOP.
  - FetchEntry struct {Word pc; Word word;}.
  - FetchState enum {FETCH_RUN, FETCH_FAULT}.
- Sub-module fetch_queue: a 2-entry FIFO of FetchEntry with push/pop/flush/full/empty.
  - Simultaneous push+pop is legal when full.
  - Flush overrides push and pop.

Test Plan:
- Reset release, fetch_ready=1 every cycle, ROM word i = i:
  - fetch_pc sequence 0,4,8,... from cycle 1.
  - fetch_word = 0,1,2,...
  - fetch_valid stays high with no bubbles.
- Backpressure:
  - Hold fetch_ready=0 for 5 cycles: the queue fills at 2 entries, pc stops at 8, and the head stays pc=0.
  - Release: heads 0,4,8 on consecutive cycles.
- Redirect to 0x40 while the queue is full:
  - Next cycle fetch_valid=0.
  - The following cycle: head fetch_pc=0x40, fetch_word=ROM[16].
  - No stale entry (0x0/0x4) is ever presented.
- Redirect to 0x42:
  - fault=1, fault_pc=0x42, fetch_valid=0.
  - A later redirect to 0x10 clears the fault, and the head becomes 0x10.
- ROM_WORDS=16, run off the end: after pc 0x3C is delivered, fault=1 with fault_pc=0x40, and no push occurs.
- With FETCH_ERASED_TRAP_EN and ROM[3]=32'hFFFF_FFFF:
  - 0x0, 0x4, 0x8 are delivered; fault_pc=0xC.
  - Without the macro: 0xC is delivered with word 32'hFFFF_FFFF.
- Assert reset_n low mid-stream, between clock edges: fetch_valid=0 and fetch_word=R_NOP immediately.
